// File: rtl/sm_run_ctrl_pkg.sv
// Shared command opcodes, controller states and halt causes for sm_run_ctrl.
package sm_run_ctrl_pkg;

  localparam logic [2:0] OpNop   = 3'd0;
  localparam logic [2:0] OpRun   = 3'd1;
  localparam logic [2:0] OpHalt  = 3'd2;
  localparam logic [2:0] OpStep  = 3'd3;
  localparam logic [2:0] OpRegRd = 3'd4;
  localparam logic [2:0] OpSetBp = 3'd5;
  localparam logic [2:0] OpClrBp = 3'd6;

  typedef enum logic [1:0] {
    StHalt  = 2'd0,
    StRun   = 2'd1,
    StStep  = 2'd2,
    StRdReg = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    CauseCmd      = 2'd0,
    CauseStepDone = 2'd1,
    CauseBreak    = 2'd2
  } cause_e;

endpackage

// File: rtl/sm_run_ctrl_bp.sv
// PC breakpoint for sm_run_ctrl: address/enable registers, resume-skip flag and comparator.
module sm_run_ctrl_bp (
  input  logic        clk,
  input  logic        rst,
  input  logic        setBp,
  input  logic        clrBp,
  input  logic [31:0] bpAddrIn,
  input  logic        resume,
  input  logic        cpuEn,
  input  logic [31:0] cpuPc,
  output logic        bpHit
);

  logic [31:0] bpAddrQ;
  logic        bpEnQ;
  logic        skipQ;

  always_ff @(posedge clk) begin
    if (rst) begin
      bpAddrQ <= '0;
      bpEnQ   <= 1'b0;
      skipQ   <= 1'b0;
    end else begin
      if (setBp) begin
        bpAddrQ <= bpAddrIn;
        bpEnQ   <= 1'b1;
      end else if (clrBp) begin
        bpEnQ <= 1'b0;
      end
      // Skip lets the instruction we stopped on execute once after a resume.
      if (resume) begin
        skipQ <= 1'b1;
      end else if (cpuEn) begin
        skipQ <= 1'b0;
      end
    end
  end

  assign bpHit = bpEnQ && (cpuPc == bpAddrQ) && !skipQ;

endmodule

// File: rtl/sm_run_ctrl.sv
// Run/halt/single-step controller for sm_cpu; shares the register debug read port.
// Optional PC breakpoint is built when SM_RUN_CTRL_BREAK_EN is defined.
module sm_run_ctrl
  import sm_run_ctrl_pkg::*;
#(
  parameter int unsigned STEP_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [31:0] cmd_arg,
  output logic        cpu_en,
  input  logic [31:0] cpu_pc,
  output logic [4:0]  reg_addr,
  input  logic [31:0] reg_data,
  input  logic [4:0]  disp_addr,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        halted,
  output logic        halt_evt,
  output logic [1:0]  halt_cause,
  output logic [31:0] cycle_cnt
);

  state_e            stateQ, stateD;
  state_e            savedQ, savedD;
  logic [STEP_W-1:0] remQ, remD;
  logic [4:0]        rdAddrQ, rdAddrD;
  logic              rspValidQ, rspValidD;
  logic [31:0]       rspDataQ, rspDataD;
  logic              haltEvtQ, haltEvtD;
  cause_e            causeQ, causeD;
  logic [31:0]       cycleCntQ;
  logic              cmdAcc;
  logic              resume;
  logic              bpHit;

  assign cmdAcc = cmd_valid && cmd_ready;

  always_comb begin
    stateD    = stateQ;
    savedD    = savedQ;
    remD      = remQ;
    rdAddrD   = rdAddrQ;
    rspValidD = 1'b0;
    rspDataD  = rspDataQ;
    haltEvtD  = 1'b0;
    causeD    = causeQ;
    resume    = 1'b0;
    unique case (stateQ)
      StHalt: begin
        if (cmdAcc) begin
          if (cmd_op == OpRun) begin
            stateD = StRun;
            resume = 1'b1;
          end else if (cmd_op == OpStep && cmd_arg[STEP_W-1:0] != '0) begin
            stateD = StStep;
            remD   = cmd_arg[STEP_W-1:0];
            resume = 1'b1;
          end else if (cmd_op == OpRegRd) begin
            stateD  = StRdReg;
            savedD  = StHalt;
            rdAddrD = cmd_arg[4:0];
          end
        end
      end
      StRun: begin
        // A breakpoint outranks any command accepted in the same cycle.
        if (bpHit) begin
          stateD   = StHalt;
          causeD   = CauseBreak;
          haltEvtD = 1'b1;
        end else if (cmdAcc && cmd_op == OpHalt) begin
          stateD   = StHalt;
          causeD   = CauseCmd;
          haltEvtD = 1'b1;
        end else if (cmdAcc && cmd_op == OpRegRd) begin
          stateD  = StRdReg;
          savedD  = StRun;
          rdAddrD = cmd_arg[4:0];
        end
      end
      StStep: begin
        if (bpHit) begin
          stateD   = StHalt;
          causeD   = CauseBreak;
          haltEvtD = 1'b1;
        end else begin
          remD = remQ - STEP_W'(1);
          if (remQ == STEP_W'(1)) begin
            stateD   = StHalt;
            causeD   = CauseStepDone;
            haltEvtD = 1'b1;
          end
        end
      end
      StRdReg: begin
        rspValidD = 1'b1;
        rspDataD  = reg_data;
        stateD    = savedQ;
      end
      default: stateD = StHalt;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stateQ    <= StHalt;
      savedQ    <= StHalt;
      remQ      <= '0;
      rdAddrQ   <= '0;
      rspValidQ <= 1'b0;
      rspDataQ  <= '0;
      haltEvtQ  <= 1'b0;
      causeQ    <= CauseCmd;
      cycleCntQ <= '0;
    end else begin
      stateQ    <= stateD;
      savedQ    <= savedD;
      remQ      <= remD;
      rdAddrQ   <= rdAddrD;
      rspValidQ <= rspValidD;
      rspDataQ  <= rspDataD;
      haltEvtQ  <= haltEvtD;
      causeQ    <= causeD;
      if (cpu_en) begin
        cycleCntQ <= cycleCntQ + 32'd1;
      end
    end
  end

`ifdef SM_RUN_CTRL_BREAK_EN
  sm_run_ctrl_bp uBp (
    .clk      (clk),
    .rst      (rst),
    .setBp    (cmdAcc && cmd_op == OpSetBp),
    .clrBp    (cmdAcc && cmd_op == OpClrBp),
    .bpAddrIn (cmd_arg),
    .resume   (resume),
    .cpuEn    (cpu_en),
    .cpuPc    (cpu_pc),
    .bpHit    (bpHit)
  );
`else
  logic unusedBp;
  assign bpHit    = 1'b0;
  assign unusedBp = ^{cpu_pc, cmd_arg, resume};
`endif

  assign cpu_en     = (stateQ == StRun || stateQ == StStep) && !bpHit;
  assign cmd_ready  = (stateQ == StHalt || stateQ == StRun);
  assign reg_addr   = (stateQ == StRdReg) ? rdAddrQ : disp_addr;
  assign halted     = (stateQ == StHalt);
  assign halt_evt   = haltEvtQ;
  assign halt_cause = causeQ;
  assign rsp_valid  = rspValidQ;
  assign rsp_data   = rspDataQ;
  assign cycle_cnt  = cycleCntQ;

endmodule

// File: tb/tb_sm_run_ctrl.sv
// Self-checking bench for sm_run_ctrl: vector table, corner sequences, random vs. model.
module tb_sm_run_ctrl;

  localparam logic [2:0] OpNop = 3'd0, OpRun = 3'd1, OpHalt = 3'd2, OpStep = 3'd3;
  localparam logic [2:0] OpRegRd = 3'd4, OpSetBp = 3'd5, OpClrBp = 3'd6;
  localparam int MHalt = 0, MRun = 1, MStep = 2, MRd = 3;
`ifdef SM_RUN_CTRL_BREAK_EN
  localparam bit BpBuild = 1'b1;
`else
  localparam bit BpBuild = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, cmd_valid, cmd_ready, cpu_en, rsp_valid, halted, halt_evt;
  logic [2:0]  cmd_op;
  logic [31:0] cmd_arg, cpu_pc, reg_data, rsp_data, cycle_cnt;
  logic [4:0]  reg_addr, disp_addr;
  logic [1:0]  halt_cause;
  logic [31:0] regFile [32];

  always #5 clk = ~clk;
  assign reg_data = regFile[reg_addr];

  sm_run_ctrl #(.STEP_W(16)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_arg(cmd_arg), .cpu_en(cpu_en), .cpu_pc(cpu_pc), .reg_addr(reg_addr),
    .reg_data(reg_data), .disp_addr(disp_addr), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .halted(halted), .halt_evt(halt_evt), .halt_cause(halt_cause), .cycle_cnt(cycle_cnt)
  );

  int nTests = 0, nFail = 0;
  bit chk = 1'b0;
  logic [31:0] pc = '0;

  // Reference model state
  int mMode, mSaved, mRem, mCause;
  logic [4:0]  mRd;
  logic        mRspV, mEvt, mBpEn, mSkip;
  logic [31:0] mRspD, mCnt, mBpAddr;
  logic        eEn, eReady, eHit;
  logic [4:0]  eRegAddr;

  // Samples of the DUT in the most recent tick
  logic sEn, sReady, sRspV, sHalted, sEvt;
  logic [4:0] sRegAddr;
  logic [1:0] sCause;
  logic [31:0] sRspD, sCnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    mMode = MHalt; mSaved = MHalt; mRem = 0; mCause = 0; mRd = '0;
    mRspV = 1'b0; mEvt = 1'b0; mBpEn = 1'b0; mSkip = 1'b0;
    mRspD = '0; mCnt = '0; mBpAddr = '0;
  endtask

  task automatic haltWith(input int c);
    mMode = MHalt; mCause = c; mEvt = 1'b1;
  endtask

  task automatic modelNext(input logic r, input logic acc, input logic [2:0] op,
                           input logic [31:0] arg);
    if (r) begin
      modelReset();
      return;
    end
    mEvt = 1'b0; mRspV = 1'b0;
    if (eEn) begin
      mCnt = mCnt + 1;
      mSkip = 1'b0;
    end
    if (BpBuild && acc && op == OpSetBp) begin
      mBpEn = 1'b1; mBpAddr = arg;
    end else if (BpBuild && acc && op == OpClrBp) begin
      mBpEn = 1'b0;
    end
    case (mMode)
      MHalt: if (acc) begin
        if (op == OpRun) begin
          mMode = MRun; mSkip = 1'b1;
        end else if (op == OpStep && arg[15:0] != 16'd0) begin
          mMode = MStep; mRem = int'(arg[15:0]); mSkip = 1'b1;
        end else if (op == OpRegRd) begin
          mSaved = MHalt; mRd = arg[4:0]; mMode = MRd;
        end
      end
      MRun: begin
        if (eHit) haltWith(2);
        else if (acc && op == OpHalt) haltWith(0);
        else if (acc && op == OpRegRd) begin
          mSaved = MRun; mRd = arg[4:0]; mMode = MRd;
        end
      end
      MStep: begin
        if (eHit) haltWith(2);
        else begin
          mRem = mRem - 1;
          if (mRem == 0) haltWith(1);
        end
      end
      default: begin
        mRspV = 1'b1; mRspD = regFile[mRd]; mMode = mSaved;
      end
    endcase
  endtask

  // One clock cycle: drive after negedge, sample/compare, advance model, cross posedge.
  task automatic tick(input logic r, input logic v, input logic [2:0] op, input logic [31:0] arg);
    rst = r; cmd_valid = v; cmd_op = op; cmd_arg = arg; cpu_pc = pc;
    #1;
    eHit     = BpBuild && mBpEn && (pc == mBpAddr) && !mSkip;
    eEn      = (mMode == MRun || mMode == MStep) && !eHit;
    eReady   = (mMode == MHalt || mMode == MRun);
    eRegAddr = (mMode == MRd) ? mRd : disp_addr;
    sEn = cpu_en; sReady = cmd_ready; sRegAddr = reg_addr; sRspV = rsp_valid;
    sRspD = rsp_data; sHalted = halted; sEvt = halt_evt; sCause = halt_cause; sCnt = cycle_cnt;
    if (chk) begin
      check("cpu_en", sEn, eEn);
      check("cmd_ready", sReady, eReady);
      check("reg_addr", sRegAddr, eRegAddr);
      check("rsp_valid", sRspV, mRspV);
      check("rsp_data", sRspD, mRspD);
      check("halted", sHalted, mMode == MHalt);
      check("halt_evt", sEvt, mEvt);
      check("halt_cause", sCause, mCause);
      check("cycle_cnt", sCnt, mCnt);
    end
    modelNext(r, v && eReady, op, arg);
    @(posedge clk);
    if (eEn) pc = pc + 1;
    @(negedge clk);
  endtask

  typedef struct {
    logic v; logic [2:0] op; logic [31:0] arg;
    logic eEn; logic eEvt; logic eHalted; logic [1:0] eCause; logic [31:0] eCnt;
  } vec_t;
  vec_t tbl [16];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] base;
    logic [2:0] rop;
    logic [31:0] rarg;
    int rr;
    for (int i = 0; i < 32; i++) regFile[i] = 32'hA500_0000 ^ (i * 32'h0101_0301);
    regFile[2] = 32'h0000_0007;
    disp_addr = 5'd9;
    modelReset();
    @(negedge clk);
    tick(1'b1, 1'b0, OpNop, '0);
    chk = 1'b1;
    tick(1'b1, 1'b1, OpRun, '0);

    // Reset then STEP 3 at edge 10
    for (int i = 0; i < 16; i++)
      tbl[i] = '{v: 1'b0, op: OpNop, arg: 32'd0, eEn: 1'b0, eEvt: 1'b0, eHalted: 1'b1,
                 eCause: 2'd0, eCnt: 32'd0};
    tbl[10].v = 1'b1; tbl[10].op = OpStep; tbl[10].arg = 32'd3;
    for (int i = 11; i <= 13; i++) begin
      tbl[i].eEn = 1'b1; tbl[i].eHalted = 1'b0; tbl[i].eCnt = 32'(i - 11);
    end
    tbl[14].eEvt = 1'b1; tbl[14].eCause = 2'd1; tbl[14].eCnt = 32'd3;
    tbl[15].eCause = 2'd1; tbl[15].eCnt = 32'd3;
    for (int i = 0; i < 16; i++) begin
      tick(1'b0, tbl[i].v, tbl[i].op, tbl[i].arg);
      check("tbl_en", sEn, tbl[i].eEn);
      check("tbl_evt", sEvt, tbl[i].eEvt);
      check("tbl_halted", sHalted, tbl[i].eHalted);
      check("tbl_cause", sCause, tbl[i].eCause);
      check("tbl_cnt", sCnt, tbl[i].eCnt);
    end

    // RUN for 20 cycles, HALT on an enabled cycle, then STEP 0
    base = 32'd3;
    tick(1'b0, 1'b1, OpRun, '0);
    for (int i = 0; i < 20; i++) tick(1'b0, 1'b0, OpNop, '0);
    tick(1'b0, 1'b1, OpHalt, '0);
    check("halt_en_last", sEn, 1'b1);
    tick(1'b0, 1'b0, OpNop, '0);
    check("run_cnt", sCnt, base + 32'd21);
    check("run_evt", sEvt, 1'b1);
    check("run_cause", sCause, 2'd0);
    tick(1'b0, 1'b1, OpStep, 32'h0001_0000);
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b0, OpNop, '0);
      check("step0_en", sEn, 1'b0);
      check("step0_evt", sEvt, 1'b0);
    end

    // REGRD while running
    tick(1'b0, 1'b1, OpRun, '0);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, OpNop, '0);
    check("rd_disp", sRegAddr, 5'd9);
    tick(1'b0, 1'b1, OpRegRd, 32'hFFFF_FFE2);
    tick(1'b0, 1'b0, OpNop, '0);
    check("rd_en", sEn, 1'b0);
    check("rd_addr", sRegAddr, 5'd2);
    check("rd_ready", sReady, 1'b0);
    tick(1'b0, 1'b0, OpNop, '0);
    check("rd_valid", sRspV, 1'b1);
    check("rd_data", sRspD, 32'h7);
    check("rd_resume", sEn, 1'b1);
    check("rd_ready2", sReady, 1'b1);
    tick(1'b0, 1'b0, OpNop, '0);
    check("rd_pulse", sRspV, 1'b0);
    tick(1'b0, 1'b1, OpHalt, '0);

    // Reset mid-STEP with a RUN on the same edge
    tick(1'b0, 1'b1, OpStep, 32'd5);
    tick(1'b0, 1'b0, OpNop, '0);
    tick(1'b0, 1'b0, OpNop, '0);
    tick(1'b1, 1'b1, OpRun, '0);
    tick(1'b0, 1'b0, OpNop, '0);
    check("rst_halted", sHalted, 1'b1);
    check("rst_en", sEn, 1'b0);
    check("rst_cnt", sCnt, 32'd0);
    check("rst_rsp", sRspD, 32'd0);
    tick(1'b0, 1'b0, OpNop, '0);
    check("rst_discard", sEn, 1'b0);

`ifdef SM_RUN_CTRL_BREAK_EN
    // Break at PC 5, then resume through it
    pc = 32'd0;
    tick(1'b0, 1'b1, OpSetBp, 32'd5);
    tick(1'b0, 1'b1, OpRun, '0);
    for (int i = 0; i < 5; i++) tick(1'b0, 1'b0, OpNop, '0);
    tick(1'b0, 1'b0, OpNop, '0);
    check("bp_pc", cpu_pc, 32'd5);
    check("bp_en", sEn, 1'b0);
    tick(1'b0, 1'b0, OpNop, '0);
    check("bp_halted", sHalted, 1'b1);
    check("bp_cause", sCause, 2'd2);
    tick(1'b0, 1'b1, OpRun, '0);
    tick(1'b0, 1'b0, OpNop, '0);
    check("bp_skip_en", sEn, 1'b1);
    tick(1'b0, 1'b0, OpNop, '0);
    check("bp_no_rebreak", sHalted, 1'b0);
    tick(1'b0, 1'b1, OpHalt, '0);
    tick(1'b0, 1'b0, OpNop, '0);

    // STEP 4 whose fourth cycle hits the breakpoint
    pc = 32'd10;
    base = mCnt;
    tick(1'b0, 1'b1, OpSetBp, 32'd13);
    tick(1'b0, 1'b1, OpStep, 32'd4);
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, OpNop, '0);
    check("bpstep_en", sEn, 1'b0);
    tick(1'b0, 1'b0, OpNop, '0);
    check("bpstep_cause", sCause, 2'd2);
    check("bpstep_cnt", sCnt, base + 32'd3);
    tick(1'b0, 1'b1, OpClrBp, '0);
`endif

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      disp_addr = 5'($urandom_range(0, 31));
      rr = int'($urandom_range(0, 99));
      rop = 3'($urandom_range(0, 7));
      rarg = $urandom;
      if (rop == OpStep) rarg = {rarg[31:16], 16'($urandom_range(0, 6))};
      if (rop == OpSetBp) rarg = pc + 32'($urandom_range(0, 8));
      if (rop == OpRun && $urandom_range(0, 1) == 0) rop = OpHalt;
      tick(rr < 2, rr < 40, rop, rarg);
    end

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
